// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, instruction size and fetch FSM states for the fetch stage.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SW       = 6'h2B;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam int         INSTR_BYTES = 4;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO; flush wins over push, push allowed when full if popping.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  logic [WIDTH-1:0]             i_din,
    output logic [WIDTH-1:0]             o_dout,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr, r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push, w_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= nxt(r_wr);
            if (w_pop) r_rd <= nxt(r_rd);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd];
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, credit-limited in-order imem requests, prefetch buffer and redirect flush.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        opcode
);
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t      r_state, w_next;
    logic [ADDR_W-1:0] r_pc, r_head_pc, w_redir_pc;
    logic [OW-1:0]     r_out, r_drop, w_count, w_left, w_dleft;
    logic [OW:0]       w_inflight;
    logic              w_accept, w_rsp, w_push, w_pop, w_empty, w_full, w_credit;
    logic [DATA_W-1:0] w_head;

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_din   (imem_rsp_data),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_redir_pc = redirect_pc & ~ADDR_W'(3);
    assign w_rsp      = imem_rsp_valid && r_out != '0;
    assign w_left     = r_out - OW'(w_rsp);
    assign w_dleft    = r_drop - OW'(w_rsp);
    // Credit counts words both in flight and buffered so a response always has a slot.
    assign w_inflight = {1'b0, r_out} + {1'b0, w_count};
    assign w_credit   = !w_full && w_inflight < (OW + 1)'(FIFO_DEPTH);
    assign w_accept   = imem_req_valid && imem_req_ready;
    assign w_push     = w_rsp && r_state == FETCH && r_drop == '0 && !redirect_valid;
    assign w_pop      = instr_valid && !stall;

    assign imem_req_addr = r_pc;
    assign instr_valid   = !w_empty && !redirect_valid;
    assign instr         = w_empty ? '0 : w_head;
    assign instr_pc      = w_empty ? '0 : r_head_pc;
    assign opcode        = instr[DATA_W-1 -: 6];

    always_comb begin
        w_next         = r_state;
        imem_req_valid = 1'b0;
        unique case (r_state)
            IDLE:  w_next = FETCH;
            FETCH: begin
                imem_req_valid = w_credit && !redirect_valid;
                w_next         = (redirect_valid && w_left != '0) ? FLUSH : FETCH;
            end
            FLUSH: w_next = (w_dleft == '0) ? FETCH : FLUSH;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_head_pc <= RESET_PC;
            r_out     <= '0;
            r_drop    <= '0;
        end else begin
            r_state   <= w_next;
            r_pc      <= redirect_valid ? w_redir_pc :
                         w_accept ? r_pc + ADDR_W'(INSTR_BYTES) : r_pc;
            r_head_pc <= redirect_valid ? w_redir_pc :
                         w_pop ? r_head_pc + ADDR_W'(INSTR_BYTES) : r_head_pc;
            r_out     <= r_out + OW'(w_accept) - OW'(w_rsp);
            r_drop    <= redirect_valid ? w_left :
                         (r_state == FLUSH && w_rsp) ? w_dleft : r_drop;
        end
    end
endmodule
